// File: rtl/snn_seq_pkg.sv
// Shared types and constants for the SNN inference sequencer.
package snn_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StInject,
        StWaitT1,
        StClr1,
        StWaitT2,
        StWaitT3,
        StWaitClr2,
        StVote
    } seq_state_t;

    localparam int unsigned NUM_CORES_FULL = 21;
    localparam int unsigned SPIKE_W        = 30;
    localparam int unsigned VOTE_W         = 16;

endpackage

// File: rtl/snn_vote_counter.sv
// Per-class saturating vote counters with a sequential argmax scan.
module snn_vote_counter
    import snn_seq_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       inc_en_i,
    input  logic [7:0] packet_out_i,
    input  logic       valid_i,
    input  logic       start_i,
    output logic [3:0] result_o,
    output logic       result_valid_o
);

    localparam int unsigned IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic [VOTE_W-1:0] cnt_q [NUM_CLASSES];
    logic [7:0]        cls;
    logic              active_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     best_idx_q;
    logic [VOTE_W-1:0] best_val_q;
    logic [3:0]        result_q;
    logic              result_valid_q;
    logic [VOTE_W-1:0] cur_val;
    logic              take;
    logic [IW-1:0]     best_idx_d;
    logic [VOTE_W-1:0] best_val_d;

    assign cls = packet_out_i % 8'(NUM_CLASSES);

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        cur_val    = cnt_q[idx_q];
        take       = cur_val > best_val_q;
        best_idx_d = take ? idx_q : best_idx_q;
        best_val_d = take ? cur_val : best_val_q;
    end

    // Counter bank: cleared per image, saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) cnt_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) cnt_q[i] <= '0;
        end else if (inc_en_i && valid_i) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                if (cls == 8'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // One counter per cycle; result registered on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q       <= 1'b0;
            idx_q          <= '0;
            best_idx_q     <= '0;
            best_val_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (start_i) begin
                active_q   <= 1'b1;
                idx_q      <= '0;
                best_idx_q <= '0;
                best_val_q <= '0;
            end else if (active_q) begin
                best_idx_q <= best_idx_d;
                best_val_q <= best_val_d;
                if (idx_q == IW'(NUM_CLASSES - 1)) begin
                    active_q       <= 1'b0;
                    result_valid_q <= 1'b1;
                    result_q       <= 4'(best_idx_d);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;

endmodule

// File: rtl/snn_inference_sequencer.sv
// Sequences one image through the RANC grid: parameter load, spike
// injection, tick/clear phases and final vote.
module snn_inference_sequencer
    import snn_seq_pkg::*;
#(
    parameter int unsigned NUM_NEURONS     = 256,
    parameter int unsigned CSRAM_WIDTH     = 368,
    parameter int unsigned NUM_GROUPS      = 9,
    parameter int unsigned CORES_PER_GROUP = 16,
    parameter int unsigned TAIL_FIRST      = 144,
    parameter int unsigned TAIL_CORES      = 5,
    parameter int unsigned NUM_CLASSES     = 9,
    parameter int unsigned TICK_GAP        = 1024,
    parameter int unsigned INJ_TIMEOUT     = 8192
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              load_tail,
    output logic                              busy,
    output logic                              cfg_rd_en,
    output logic [7:0]                        cfg_rd_core,
    output logic [$clog2(NUM_NEURONS)-1:0]    cfg_rd_addr,
    input  logic [CSRAM_WIDTH-1:0]            cfg_rd_data,
    output logic                              param_wen,
    output logic [$clog2(NUM_NEURONS)-1:0]    param_addr,
    output logic [CSRAM_WIDTH-1:0]            param_data_in,
    output logic [$clog2(NUM_CORES_FULL)-1:0] num_core_write,
    input  logic                              spk_valid,
    input  logic [SPIKE_W-1:0]                spk_data,
    output logic                              spk_ready,
    output logic                              input_buffer_empty,
    output logic [SPIKE_W-1:0]                packet_in,
    input  logic                              ren_to_input_buffer,
    output logic                              tick,
    output logic                              tick2,
    output logic                              tick3,
    output logic                              clr_avr,
    output logic                              clr_spiked,
    output logic                              clr_avr_2,
    output logic                              clr_avr_3,
    output logic                              clr_spiked_2,
    output logic                              clr_spiked_3,
    input  logic [7:0]                        packet_out,
    input  logic                              packet_out_valid,
    output logic [3:0]                        result,
    output logic                              result_valid,
    output logic                              timeout_err
);

    localparam int unsigned AW   = $clog2(NUM_NEURONS);
    localparam int unsigned CW   = $clog2(NUM_CORES_FULL);
    localparam int unsigned GW   = $clog2(NUM_GROUPS + 1);
    localparam int unsigned TLIM = (2 * TICK_GAP > INJ_TIMEOUT) ? 2 * TICK_GAP : INJ_TIMEOUT;
    localparam int unsigned TW   = $clog2(TLIM + 1);

    localparam logic [TW-1:0] GapEnd  = TW'(TICK_GAP - 1);
    localparam logic [TW-1:0] Gap2End = TW'(2 * TICK_GAP - 1);
    localparam logic [TW-1:0] InjEnd  = TW'(INJ_TIMEOUT - 1);
    localparam logic [CW-1:0] NcwFull = CW'(NUM_CORES_FULL);
    localparam logic [CW-1:0] NcwGrp  = CW'(CORES_PER_GROUP);

    seq_state_t        state_q;
    logic [GW-1:0]     g_q;
    logic              tail_q;
    logic [CW-1:0]     ci_q;
    logic [AW-1:0]     row_q;
    logic              rd_done_q;
    logic [1:0]        drain_q;
    logic [TW-1:0]     timer_q;
    logic [CW-1:0]     ncw_q;
    logic              cfg_rd_en_q;
    logic [7:0]        cfg_rd_core_q;
    logic [AW-1:0]     cfg_rd_addr_q;
    logic              param_wen_q;
    logic [AW-1:0]     param_addr_q;
    logic [SPIKE_W-1:0] packet_in_q;
    logic              tick_q, tick2_q, tick3_q;
    logic              clr1_q, clr2_q;
    logic              timeout_q;
    logic              vote_start_q;
    logic [7:0]        rd_core_d;
    logic              in_inject;
    logic              spk_fire;
    logic              vote_done;

    // Layer-1 slots map to the current group, slots past them to the tail cores.
    always_comb begin
        if (ci_q >= NcwGrp) begin
            rd_core_d = 8'(TAIL_FIRST) + 8'(ci_q) - 8'(CORES_PER_GROUP);
        end else begin
            rd_core_d = 8'(g_q) * 8'(CORES_PER_GROUP) + 8'(ci_q);
        end
    end

    assign in_inject = (state_q == StInject);
    assign spk_fire  = in_inject && ren_to_input_buffer && spk_valid;

    // Main sequencer: all outputs registered except the spike handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            g_q           <= '0;
            tail_q        <= 1'b0;
            ci_q          <= '0;
            row_q         <= '0;
            rd_done_q     <= 1'b0;
            drain_q       <= '0;
            timer_q       <= '0;
            ncw_q         <= '0;
            cfg_rd_en_q   <= 1'b0;
            cfg_rd_core_q <= '0;
            cfg_rd_addr_q <= '0;
            param_wen_q   <= 1'b0;
            param_addr_q  <= '0;
            packet_in_q   <= '0;
            tick_q        <= 1'b0;
            tick2_q       <= 1'b0;
            tick3_q       <= 1'b0;
            clr1_q        <= 1'b0;
            clr2_q        <= 1'b0;
            timeout_q     <= 1'b0;
            vote_start_q  <= 1'b0;
        end else begin
            cfg_rd_en_q  <= 1'b0;
            tick_q       <= 1'b0;
            tick2_q      <= 1'b0;
            tick3_q      <= 1'b0;
            clr1_q       <= 1'b0;
            clr2_q       <= 1'b0;
            vote_start_q <= 1'b0;
            // ROM data lands one cycle after the read; the write follows it.
            param_wen_q  <= cfg_rd_en_q;
            param_addr_q <= cfg_rd_addr_q;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        g_q       <= '0;
                        tail_q    <= load_tail;
                        timeout_q <= 1'b0;
                        ci_q      <= '0;
                        row_q     <= '0;
                        rd_done_q <= 1'b0;
                        drain_q   <= '0;
                        ncw_q     <= load_tail ? NcwFull : NcwGrp;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    if (!rd_done_q) begin
                        cfg_rd_en_q   <= 1'b1;
                        cfg_rd_core_q <= rd_core_d;
                        cfg_rd_addr_q <= row_q;
                        row_q         <= row_q + 1'b1;
                        if (row_q == AW'(NUM_NEURONS - 1)) begin
                            row_q <= '0;
                            if (ci_q == ncw_q - 1'b1) rd_done_q <= 1'b1;
                            else                      ci_q      <= ci_q + 1'b1;
                        end
                    end else if (drain_q == 2'd2) begin
                        // Last read, last write, one quiet cycle, then inject.
                        state_q <= StInject;
                        timer_q <= '0;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                StInject: begin
                    if (spk_fire && !spk_data[0]) packet_in_q <= spk_data;
                    if (spk_fire && spk_data[0]) begin
                        g_q     <= g_q + 1'b1;
                        timer_q <= '0;
                        state_q <= StWaitT1;
                    end else if (timer_q == InjEnd) begin
                        // Group counter untouched so the same group reloads.
                        timeout_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= StWaitT1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StWaitT1: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == GapEnd) tick_q <= 1'b1;
                    if (timer_q == Gap2End) begin
                        clr1_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= StClr1;
                    end
                end
                StClr1: begin
                    if (g_q < GW'(NUM_GROUPS)) begin
                        ci_q      <= '0;
                        row_q     <= '0;
                        rd_done_q <= 1'b0;
                        drain_q   <= '0;
                        ncw_q     <= (g_q == '0 && tail_q) ? NcwFull : NcwGrp;
                        state_q   <= StLoad;
                    end else begin
                        timer_q <= '0;
                        state_q <= StWaitT2;
                    end
                end
                StWaitT2: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == GapEnd) begin
                        tick2_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= StWaitT3;
                    end
                end
                StWaitT3: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == GapEnd) begin
                        tick3_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= StWaitClr2;
                    end
                end
                StWaitClr2: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == GapEnd) begin
                        clr2_q       <= 1'b1;
                        vote_start_q <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= StVote;
                    end
                end
                StVote: begin
                    if (vote_done) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    snn_vote_counter #(
        .NUM_CLASSES (NUM_CLASSES)
    ) u_vote (
        .clk            (clk),
        .rst            (rst),
        .clear_i        ((state_q == StIdle) && start),
        .inc_en_i       (state_q != StIdle),
        .packet_out_i   (packet_out),
        .valid_i        (packet_out_valid),
        .start_i        (vote_start_q),
        .result_o       (result),
        .result_valid_o (vote_done)
    );

    assign busy               = (state_q != StIdle);
    assign cfg_rd_en          = cfg_rd_en_q;
    assign cfg_rd_core        = cfg_rd_core_q;
    assign cfg_rd_addr        = cfg_rd_addr_q;
    assign param_wen          = param_wen_q;
    assign param_addr         = param_addr_q;
    assign param_data_in      = param_wen_q ? cfg_rd_data : '0;
    assign num_core_write     = ncw_q;
    assign spk_ready          = spk_fire;
    assign input_buffer_empty = !(in_inject && spk_valid);
    assign packet_in          = packet_in_q;
    assign tick               = tick_q;
    assign tick2              = tick2_q;
    assign tick3              = tick3_q;
    assign clr_avr            = clr1_q;
    assign clr_spiked         = clr1_q;
    assign clr_avr_2          = clr2_q;
    assign clr_avr_3          = clr2_q;
    assign clr_spiked_2       = clr2_q;
    assign clr_spiked_3       = clr2_q;
    assign result_valid       = vote_done;
    assign timeout_err        = timeout_q;

endmodule
